clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//   Multi-channel programmable clock-enable / slow-clock generator; successor to the fixed 4 ms divider.
//   Each channel divides clk by a runtime-writable half-period D and emits a registered square wave plus a one-cycle tick.
//   Feeds display scan, key debounce and game-timer logic; tick is the preferred qualifier, sq_out is for legacy users.
// PARAMETERS
//   CHANNELS  4        number of independent divider channels (1..16)
//   CNT_W     32       counter / divisor width in bits
//   DIV_INIT  200_000  reset value of every channel's divisor D (2 ms half-period, 4 ms period at 100 MHz)
//   CH_W      $clog2(CHANNELS) (min 1)  width of wr_ch; derived, not overridden
// PORTS
//   clk       in   1               system clock
//   rst_n     in   1               asynchronous active-low reset
//   sync_clr  in   1               synchronous phase-align: clear all counters and outputs
//   wr_en     in   1               divisor write strobe, one cycle
//   wr_ch     in   CH_W            channel index for the write
//   wr_div    in   CNT_W           new half-period D; 0 = disable channel
//   sq_out    out  CHANNELS        per-channel square wave, period 2*D clk cycles
//   tick      out  CHANNELS        per-channel one-cycle pulse, every D clk cycles
//   pending   out  CHANNELS        1 = written divisor waiting for next terminal count
// BEHAVIOUR
//   Reset (rst_n=0, async): cnt=0, active D=DIV_INIT, shadow=DIV_INIT, sq_out=0, tick=0, pending=0.
//   Per channel, with D!=0, each clk edge:
//   - cnt!=D-1: cnt<=cnt+1 and tick<=0.
//   - cnt==D-1 (terminal): cnt<=0, tick<=1, sq_out<=~sq_out.
//   - After rst_n release the first tick/toggle is registered on the D-th rising edge.
//   - tick and sq_out are registered outputs; there is no combinational path from any input.
//   D==1: tick stays high continuously and sq_out toggles every cycle (clk/2).
//   D==0: channel disabled; cnt held 0, tick=0, sq_out held at 0 (forced low on the first disabled cycle).
//   Write (wr_en=1, wr_ch<CHANNELS):
//   - Active D!=0: wr_div goes into the shadow register and pending<=1.
//   - The shadow is copied to active D on the next terminal count, so the current half-period completes
//     (glitch-free); pending then clears on that same edge.
//   - Active D==0: the write applies immediately. cnt<=0, pending stays 0, counting starts on the next edge.
//   - A repeated write while pending=1 overwrites the shadow; last write wins.
//   - wr_ch>=CHANNELS: write ignored, no state change.
//   sync_clr=1, all channels: cnt<=0, sq_out<=0, tick<=0.
//   - Any pending shadow is applied immediately and pending<=0. Divisors are otherwise preserved.
//   - sync_clr has priority over a terminal count on the same edge.
//   - sync_clr together with wr_en: the write value becomes active D directly (not shadowed).
//   - Counting resumes on the edge after sync_clr deasserts.
//   Counter arithmetic is unsigned CNT_W bits, compare against D-1. Because D>=1 when counting,
//   cnt never wraps past 2^CNT_W-1.
//   rst_n assertion mid-period aborts immediately; there is no partial tick.
// STRUCTURE
//   Package clk_div_pkg: CNT_W_DEF, DIV_INIT_DEF, DIV_DISABLE (0) constants.
//   Sub-module clk_div_chan: one channel (cnt, active D, shadow, pending, sq, tick).
//   - Instantiated CHANNELS times by a generate loop.
//   - Top level does only the wr_ch decode (one-hot write enable with range check) and the sync_clr fan-out.
// TESTING
//   1 Reset, DIV_INIT overridden to 3, 20 cycles -> tick high on edges 3,6,9,...
//     sq_out toggles on the same edges (period 6); pending=0.
//   2 Ch1 running D=4, write wr_div=2 mid-period -> pending[1]=1 until the current terminal count,
//     then ticks every 2 cycles; no sq_out high/low phase shorter than 4 before the switch.
//   3 Write D=0 to ch2 -> tick[2]=0 and sq_out[2]=0 next cycle.
//     Then write D=5 -> first tick exactly 5 edges after the write edge.
//   4 Channels with D=3 and D=5 are out of phase; pulse sync_clr for one cycle -> all sq_out=0 and cnt=0.
//     Both tick together 3 and 5 edges after release, and again at 15.
//   5 wr_en with wr_ch=CHANNELS (CHANNELS=5 so the index is representable) -> no channel changes.
//     Then wr_en and sync_clr together on ch0 with D=7 -> ch0 ticks 7 edges after release, pending[0]=0.
//   6 Assert rst_n low asynchronously mid-count with D=1 and D=6 -> all outputs 0 with no clk edge.
//     Divisors return to DIV_INIT.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults for the multi-channel clock divider
package clk_div_pkg;
  localparam int CNT_W_DEF    = 32;
  localparam int DIV_INIT_DEF = 200_000;
  localparam int DIV_DISABLE  = 0;
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with shadowed, glitch-free divisor updates
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int             CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_INIT_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_clr,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  output logic             sq_out,
  output logic             tick,
  output logic             pending
);
  logic [CNT_W-1:0] cnt, d, shadow;
  logic disabled, terminal;
  assign disabled = d == CNT_W'(DIV_DISABLE);
  assign terminal = cnt == d - CNT_W'(1);
  // counter, divisor swap on terminal count, sync_clr phase alignment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt     <= '0;
      d       <= DIV_INIT;
      shadow  <= DIV_INIT;
      pending <= 1'b0;
      sq_out  <= 1'b0;
      tick    <= 1'b0;
    end else if (sync_clr) begin
      cnt     <= '0;
      sq_out  <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      d       <= wr_en ? wr_div : pending ? shadow : d;
    end else if (disabled) begin
      cnt    <= '0;
      sq_out <= 1'b0;
      tick   <= 1'b0;
      if (wr_en) d <= wr_div;
    end else begin
      cnt     <= terminal ? '0 : cnt + CNT_W'(1);
      tick    <= terminal;
      sq_out  <= sq_out ^ terminal;
      d       <= terminal && pending ? shadow : d;
      pending <= wr_en | (pending & ~terminal);
      if (wr_en) shadow <= wr_div;
    end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: programmable multi-channel clock-enable / slow-clock generator
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DIV_INIT = DIV_INIT_DEF,
  localparam int CH_W    = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sync_clr,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [CNT_W-1:0]    wr_div,
  output logic [CHANNELS-1:0] sq_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic wr_hit;
    assign wr_hit = wr_en && 32'(wr_ch) == c;
    clk_div_chan #(.CNT_W(CNT_W), .DIV_INIT(CNT_W'(DIV_INIT))) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .sync_clr(sync_clr),
      .wr_en   (wr_hit),
      .wr_div  (wr_div),
      .sq_out  (sq_out[c]),
      .tick    (tick[c]),
      .pending (pending[c])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: randomized and directed checks against an edges-remaining reference model
module tb_clk_div_multi;
  localparam int CH = 5;
  localparam int W  = 16;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sync_clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_ch = '0;
  logic [W-1:0]  wr_div = '0;
  logic [CH-1:0] sq_out, tick, pending;
  int n_tests = 0;
  int n_fail = 0;
  int m_div[CH], m_sh[CH], m_left[CH];
  bit m_pend[CH], m_sq[CH], m_tick[CH];

  clk_div_multi #(.CHANNELS(CH), .CNT_W(W), .DIV_INIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_div(wr_div), .sq_out(sq_out), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_div[c] = 3; m_sh[c] = 3; m_left[c] = 3;
      m_pend[c] = 0; m_sq[c] = 0; m_tick[c] = 0;
    end
  endfunction

  // m_left = edges still to go until this channel's next tick
  function automatic void model_edge();
    for (int c = 0; c < CH; c++) begin
      bit wr = wr_en && int'(wr_ch) == c;
      if (sync_clr) begin
        m_div[c] = wr ? int'(wr_div) : m_pend[c] ? m_sh[c] : m_div[c];
        m_pend[c] = 0; m_left[c] = m_div[c]; m_sq[c] = 0; m_tick[c] = 0;
      end else if (m_div[c] == 0) begin
        m_sq[c] = 0; m_tick[c] = 0;
        if (wr) begin m_div[c] = int'(wr_div); m_left[c] = m_div[c]; end
      end else begin
        m_left[c]--;
        m_tick[c] = m_left[c] == 0;
        if (m_tick[c]) begin
          m_sq[c] = !m_sq[c];
          if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
          m_left[c] = m_div[c];
        end
        if (wr) begin m_sh[c] = int'(wr_div); m_pend[c] = 1; end
      end
    end
  endfunction

  function automatic logic [CH-1:0] pack(input int sel);
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = sel == 0 ? m_sq[c] : sel == 1 ? m_tick[c] : m_pend[c];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check("sq_out", 32'(sq_out), 32'(pack(0)));
    check("tick", 32'(tick), 32'(pack(1)));
    check("pending", 32'(pending), 32'(pack(2)));
  endtask

  task automatic write(input int ch, input int div);
    wr_en = 1'b1; wr_ch = 3'(ch); wr_div = W'(div);
    step();
    wr_en = 1'b0;
  endtask

  task automatic first_tick(input string tag, input int ch, input int exp);
    int n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step();
      if (tick[ch]) n = i;
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    model_reset();
    #2;
    check("reset_sq", 32'(sq_out), 0);
    check("reset_tick", 32'(tick), 0);
    check("reset_pending", 32'(pending), 0);
    #10 rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      check("t1_tick", 32'(tick[0]), 32'(n % 3 == 0));
    end
    write(1, 4);
    for (int i = 0; i < 9; i++) step();
    write(1, 2);
    check("t2_pending", 32'(pending[1]), 1);
    for (int i = 0; i < 12; i++) step();
    write(2, 0);
    check("t3_tick_off", 32'(tick[2]), 0);
    check("t3_sq_off", 32'(sq_out[2]), 0);
    step();
    write(2, 5);
    first_tick("t3_first_tick", 2, 5);
    write(3, 5);
    for (int i = 0; i < 7; i++) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    check("t4_sq_clr", 32'(sq_out), 0);
    for (int n = 1; n <= 15; n++) begin
      step();
      if (n == 3) check("t4_tick3", 32'(tick[0]), 1);
      if (n == 5) check("t4_tick5", 32'(tick[3]), 1);
      if (n == 15) check("t4_tick15", 32'({tick[3], tick[0]}), 3);
    end
    write(5, 9);
    sync_clr = 1'b1;
    write(0, 7);
    sync_clr = 1'b0;
    check("t5_pending0", 32'(pending[0]), 0);
    first_tick("t5_first_tick", 0, 7);
    for (int i = 0; i < 400; i++) begin
      wr_en = $urandom_range(0, 7) == 0;
      wr_ch = 3'($urandom_range(0, 5));
      wr_div = W'($urandom_range(0, 6));
      sync_clr = $urandom_range(0, 39) == 0;
      step();
    end
    wr_en = 1'b0; sync_clr = 1'b0;
    sync_clr = 1'b1;
    write(0, 1);
    sync_clr = 1'b0;
    write(1, 6);
    for (int i = 0; i < 4; i++) step();
    check("t6_tick_d1", 32'(tick[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_sq", 32'(sq_out), 0);
    check("t6_async_tick", 32'(tick), 0);
    check("t6_async_pending", 32'(pending), 0);
    model_reset();
    rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      check("t6_div_init", 32'(tick[1]), 32'(n % 3 == 0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
